// File: rtl/kmkz_ahb_pkg.sv
// kmkz_ahb_pkg: shared AHB-Lite encodings, owner encoding and the address-phase bundle
package kmkz_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  localparam int PH_W = 43;
  typedef enum logic [1:0] {OWN_NONE, OWN_DO, OWN_TI} owner_e;
  typedef struct packed {
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [2:0]  hsize;
  } ahb_addr_t;
  localparam ahb_addr_t PH_IDLE = '{haddr: '0, hburst: '0, hmastlock: 1'b0, hprot: HPROT_DEFAULT, hsize: '0};
endpackage

// File: rtl/kmkz_ahb_holdreg.sv
// kmkz_ahb_holdreg: per-master buffer for an accepted but not yet issued address phase
module kmkz_ahb_holdreg
  import kmkz_ahb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PH_W-1:0] live_ph,
  input  logic            live_write,
  input  logic [1:0]      live_trans,
  input  logic            hready,
  input  logic            grant,
  input  logic            hready_sh,
  output logic            req,
  output logic            hold_valid,
  output logic [PH_W-1:0] ph,
  output logic            write,
  output logic [1:0]      trans
);
  logic [PH_W-1:0] held_ph;
  logic held_write, live_req, take;
  assign live_req = live_trans[1] && hready;
  assign take = grant && hready_sh;
  assign req = hold_valid || live_req;
  assign ph = hold_valid ? held_ph : live_ph;
  assign write = hold_valid ? held_write : live_write;
  assign trans = hold_valid ? HTRANS_NONSEQ : live_trans;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      hold_valid <= 1'b0;
      held_ph <= '0;
      held_write <= 1'b0;
    end else if (take) begin
      hold_valid <= 1'b0;
    end else if (live_req && !hold_valid) begin
      hold_valid <= 1'b1;
      held_ph <= live_ph;
      held_write <= live_write;
    end
endmodule

// File: rtl/kmkz_ahb_arbiter.sv
// kmkz_ahb_arbiter: debugger-first two-master AHB-Lite arbiter with CPU anti-starvation
module kmkz_ahb_arbiter
  import kmkz_ahb_pkg::*;
#(
  parameter int DBG_MAX_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] HADDR_DO,
  input  logic [2:0]  HBURST_DO,
  input  logic        HMASTLOCK_DO,
  input  logic [3:0]  HPROT_DO,
  input  logic [2:0]  HSIZE_DO,
  input  logic [1:0]  HTRANS_DO,
  input  logic        HWRITE_DO,
  input  logic [31:0] HWDATA_DO,
  output logic [31:0] HRDATA_DO,
  output logic        HREADY_DO,
  output logic        HRESP_DO,
  input  logic [31:0] HADDR_TI,
  input  logic [2:0]  HBURST_TI,
  input  logic        HMASTLOCK_TI,
  input  logic [3:0]  HPROT_TI,
  input  logic [2:0]  HSIZE_TI,
  input  logic [1:0]  HTRANS_TI,
  input  logic        HWRITE_TI,
  input  logic [31:0] HWDATA_TI,
  output logic [31:0] HRDATA_TI,
  output logic        HREADY_TI,
  output logic        HRESP_TI,
  output logic [31:0] HADDR_SH,
  output logic [2:0]  HBURST_SH,
  output logic        HMASTLOCK_SH,
  output logic [3:0]  HPROT_SH,
  output logic [2:0]  HSIZE_SH,
  output logic [1:0]  HTRANS_SH,
  output logic        HWRITE_SH,
  output logic [31:0] HWDATA_SH,
  input  logic [31:0] HRDATA_SH,
  input  logic        HREADY_SH,
  input  logic        HRESP_SH
);
  localparam logic [3:0] MAX_RUN = 4'(DBG_MAX_RUN);
  owner_e owner_q, data_owner, arb, grant;
  ahb_addr_t ph_do, ph_ti, ph_sh;
  logic [1:0] trans_do, trans_ti;
  logic [3:0] dbg_run;
  logic req_do, req_ti, hold_do, hold_ti, write_do, write_ti, lock_q, run_q, keep;
  kmkz_ahb_holdreg u_hold_do (
    .clk_i(clk_i), .rst_i(rst_i),
    .live_ph({HADDR_DO, HBURST_DO, HMASTLOCK_DO, HPROT_DO, HSIZE_DO}),
    .live_write(HWRITE_DO), .live_trans(HTRANS_DO), .hready(HREADY_DO),
    .grant(grant == OWN_DO), .hready_sh(HREADY_SH),
    .req(req_do), .hold_valid(hold_do), .ph(ph_do), .write(write_do), .trans(trans_do)
  );
  kmkz_ahb_holdreg u_hold_ti (
    .clk_i(clk_i), .rst_i(rst_i),
    .live_ph({HADDR_TI, HBURST_TI, HMASTLOCK_TI, HPROT_TI, HSIZE_TI}),
    .live_write(HWRITE_TI), .live_trans(HTRANS_TI), .hready(HREADY_TI),
    .grant(grant == OWN_TI), .hready_sh(HREADY_SH),
    .req(req_ti), .hold_valid(hold_ti), .ph(ph_ti), .write(write_ti), .trans(trans_ti)
  );
  // BUSY and SEQ both have bit 0 set, so bit 0 marks a burst continuation
  assign keep = owner_q == OWN_DO ? (trans_do[0] || lock_q) :
                owner_q == OWN_TI ? (trans_ti[0] || lock_q) : 1'b0;
  assign arb = keep ? owner_q :
               (req_ti && !(dbg_run == MAX_RUN && req_do)) ? OWN_TI :
               req_do ? OWN_DO : OWN_NONE;
  assign grant = !run_q ? OWN_NONE : HREADY_SH ? arb : owner_q;
  assign ph_sh = grant == OWN_DO ? ph_do : grant == OWN_TI ? ph_ti : PH_IDLE;
  assign HTRANS_SH = grant == OWN_DO ? trans_do : grant == OWN_TI ? trans_ti : HTRANS_IDLE;
  assign HWRITE_SH = grant == OWN_DO ? write_do : grant == OWN_TI ? write_ti : 1'b0;
  assign HADDR_SH = ph_sh.haddr;
  assign HBURST_SH = ph_sh.hburst;
  assign HMASTLOCK_SH = ph_sh.hmastlock;
  assign HPROT_SH = ph_sh.hprot;
  assign HSIZE_SH = ph_sh.hsize;
  assign HWDATA_SH = data_owner == OWN_DO ? HWDATA_DO : data_owner == OWN_TI ? HWDATA_TI : '0;
  assign HRDATA_DO = HRDATA_SH;
  assign HRDATA_TI = HRDATA_SH;
  assign HREADY_DO = data_owner == OWN_DO ? HREADY_SH : !hold_do;
  assign HREADY_TI = data_owner == OWN_TI ? HREADY_SH : !hold_ti;
  assign HRESP_DO = data_owner == OWN_DO && HRESP_SH;
  assign HRESP_TI = data_owner == OWN_TI && HRESP_SH;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      run_q <= 1'b0;
      owner_q <= OWN_NONE;
      data_owner <= OWN_NONE;
      lock_q <= 1'b0;
      dbg_run <= '0;
    end else begin
      run_q <= 1'b1;
      if (HREADY_SH) begin
        owner_q <= grant;
        lock_q <= HTRANS_SH[1] && HMASTLOCK_SH;
        data_owner <= HTRANS_SH == HTRANS_IDLE ? OWN_NONE : grant;
        dbg_run <= (!req_do || grant == OWN_DO) ? '0 :
                   (grant == OWN_TI && dbg_run != MAX_RUN) ? dbg_run + 4'd1 : dbg_run;
      end
    end
endmodule
